writeback_unit: RTL and testbench
=================================

# writeback_unit

Write-side driver for the CPU core's register file. It accepts completed ALU results and load requests, waits for the memory read response on loads, and extracts and sign- or zero-extends byte, halfword and word data. It then issues exactly one registered write (we/rd/rd_data) per accepted operation. It also exports the destination of an outstanding load so decode can stall on read-after-write hazards.

## Interface
- Parameters: none. The register count follows the `RV32I` define: 32 registers when defined, 16 otherwise.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered this cycle
- alu_rd  in  5  ALU destination register
- alu_result  in  32  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- ld_valid  in  1  load request offered
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type (RV32I funct3 encoding)
- ld_addr_lo  in  2  byte offset of load address
- ld_ready  out  1  load request accepted this cycle (combinational)
- mem_rdata  in  32  memory read word
- mem_rvalid  in  1  mem_rdata valid; one-cycle pulse
- pend_valid  out  1  a load is outstanding
- pend_rd  out  5  destination of the outstanding load
- we  out  1  register file write enable
- rd  out  5  register file write address
- rd_data  out  32  register file write data

## Operation
- States:
  - IDLE: no load outstanding.
  - LOAD_WAIT: load captured; waiting for mem_rvalid.
- IDLE behaviour:
  - ld_ready = 1.
  - alu_ready = !ld_valid. Loads have priority when both are offered.
- LOAD_WAIT behaviour:
  - ld_ready = 0 and alu_ready = 0.
- Load accept (ld_valid && ld_ready):
  - Capture ld_rd, ld_funct3 and ld_addr_lo.
  - Move to LOAD_WAIT.
- ALU accept (alu_valid && alu_ready):
  - Register a write of alu_result to alu_rd.
  - State stays IDLE.
- LOAD_WAIT with mem_rvalid = 1:
  - Format mem_rdata and register a write to the captured rd.
  - Return to IDLE.
- mem_rvalid in IDLE is ignored; no write, no error.
- Load formatting, with byte lane b = ld_addr_lo and halfword lane h = ld_addr_lo[1]:
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend halfword h.
  - 010 LW: full word; ld_addr_lo is ignored.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend halfword h.
  - 011, 110, 111: treated as LW.
- Write suppression:
  - A destination of 0, or (without `RV32I) any destination with bit 4 set, produces we = 0.
  - The handshake and state transition still complete normally.
- pend_valid = (state == LOAD_WAIT); pend_rd = captured rd.
  - Both are asserted even when the write will be suppressed.
  - pend_rd = 0 in IDLE.

## Timing
- Reset values: we = 0, rd = 0, rd_data = 0, state IDLE, pend_valid = 0, pend_rd = 0, captured fields 0.
- we, rd and rd_data are registered. we is high for exactly one cycle per write and is otherwise 0.
- rd and rd_data hold their last value when we = 0.
- ALU latency: accept at cycle N gives we = 1 at N+1.
- Load latency:
  - Accept at N gives pend_valid = 1 from N+1.
  - mem_rvalid at cycle M (earliest M = N+1) gives we = 1 and pend_valid = 0 at M+1.
- The next accept is possible at M+1, so back-to-back writes are possible with no bubble.
- Throughput: one ALU write per cycle in IDLE with no load pending.
- Reset mid-load discards the outstanding load, and no write is issued. A mem_rvalid after reset release is ignored.

## Structure
- Shared package / defines.v:
  - funct3 load encodings (LB, LH, LW, LBU, LHU).
  - State encodings for IDLE and LOAD_WAIT.
- One natural sub-module: load_formatter, combinational, with inputs (funct3, addr_lo, rdata) and output (formatted 32-bit word). It is reused by any future LSU path.
- The FSM, handshake logic and output registers live in writeback_unit.

## Test plan
- Reset then ALU: alu_valid with rd = 5, result 0xDEADBEEF → alu_ready = 1; next cycle we = 1, rd = 5, rd_data = 0xDEADBEEF; following cycle we = 0.
- Load sign handling, mem_rdata = 0x80FF7F01:
  - LB at offset 2 → rd_data 0xFFFFFFFF.
  - LBU at offset 3 → 0x00000080.
  - LH at offset 2 → 0xFFFF80FF.
  - LHU at offset 0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Priority and stall:
  - ld_valid and alu_valid in the same cycle → ld_ready = 1 and alu_ready = 0.
  - While in LOAD_WAIT, alu_ready stays 0 and pend_valid = 1 with pend_rd = ld_rd.
  - After mem_rvalid, the ALU operation is accepted on the following cycle.
- Suppression:
  - ALU write to rd = 0 → we = 0.
  - Without `RV32I, load to rd = 17 → handshake completes, pend_rd = 17, we stays 0.
- Reset during LOAD_WAIT → pend_valid = 0 immediately; a later mem_rvalid produces no write.
- Back-to-back: mem_rvalid at M plus a new ALU offer at M+1 → writes at M+1 and M+2 with correct rd values.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the register-file writeback path: load funct3 codes,
// FSM states and the register-count dependent write filter.
package writeback_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

`ifdef RV32I
    localparam int NUM_REGS = 32;
`else
    localparam int NUM_REGS = 16;
`endif

    // x0 is hardwired; on the 16-register build anything above x15 does not exist.
    function automatic logic rd_writable(input logic [4:0] r);
        logic ok;
        ok = (r != 5'd0);
        if (NUM_REGS == 16 && r[4])
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Extracts the addressed byte/halfword from a memory read word and extends it.
// Purely combinational so an LSU path can reuse it.
module load_formatter
    import writeback_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] formatted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        formatted = rdata;
        case (funct3)
            F3_LB:   formatted = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   formatted = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  formatted = {24'd0, byte_sel};
            F3_LHU:  formatted = {16'd0, half_sel};
            default: formatted = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write driver: one registered write per accepted ALU result or
// completed load, with the outstanding load's destination exported for hazards.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    output logic        ld_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        pend_valid,
    output logic [4:0]  pend_rd,
    output logic        we,
    output logic [4:0]  rd,
    output logic [31:0] rd_data
);

    wb_state_t   state;
    logic [4:0]  cap_rd;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_addr_lo;
    logic [31:0] ld_data;

    load_formatter u_fmt (
        .funct3    (cap_funct3),
        .addr_lo   (cap_addr_lo),
        .rdata     (mem_rdata),
        .formatted (ld_data)
    );

    // Loads win when both are offered; nothing is accepted while a load is out.
    assign ld_ready   = (state == IDLE);
    assign alu_ready  = (state == IDLE) && !ld_valid;
    assign pend_valid = (state == LOAD_WAIT);
    assign pend_rd    = pend_valid ? cap_rd : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cap_rd      <= 5'd0;
            cap_funct3  <= 3'd0;
            cap_addr_lo <= 2'd0;
            we          <= 1'b0;
            rd          <= 5'd0;
            rd_data     <= 32'd0;
        end else begin
            we <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        cap_rd      <= ld_rd;
                        cap_funct3  <= ld_funct3;
                        cap_addr_lo <= ld_addr_lo;
                        state       <= LOAD_WAIT;
                    end else if (alu_valid && rd_writable(alu_rd)) begin
                        we      <= 1'b1;
                        rd      <= alu_rd;
                        rd_data <= alu_result;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        // Suppressed writes still retire the load.
                        if (rd_writable(cap_rd)) begin
                            we      <= 1'b1;
                            rd      <= cap_rd;
                            rd_data <= ld_data;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed plus randomized checks of writeback_unit against a behavioural model.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] rd_data;

    int errors = 0;
    int checks = 0;

    writeback_unit dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .ld_ready(ld_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .pend_valid(pend_valid), .pend_rd(pend_rd), .we(we), .rd(rd), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input int unsigned off,
                                            input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic bit ref_writable(input int unsigned r);
`ifdef RV32I
        return r != 0;
`else
        return r != 0 && r < 16;
`endif
    endfunction

    // directed load table against mem word 0x80FF7F01
    logic [2:0]  t_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [1:0]  t_off [6] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [31:0] t_exp [6] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                               32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};

    // random-phase model state
    bit          m_pend;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    bit          e_we;

    initial begin
        rst_n = 1'b0; alu_valid = 0; alu_rd = 0; alu_result = 0;
        ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
        mem_rdata = 0; mem_rvalid = 0;
        #1;
        check("rst_we", 32'(we), 0);
        check("rst_rd", 32'(rd), 0);
        check("rst_data", rd_data, 0);
        check("rst_pend_valid", 32'(pend_valid), 0);
        check("rst_pend_rd", 32'(pend_rd), 0);
        check("rst_ld_ready", 32'(ld_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // ALU write
        alu_valid = 1; alu_rd = 5; alu_result = 32'hDEADBEEF;
        #1 check("alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 0;
        check("alu_we", 32'(we), 1);
        check("alu_rd", 32'(rd), 5);
        check("alu_data", rd_data, 32'hDEADBEEF);
        tick();
        check("alu_we_drop", 32'(we), 0);
        check("alu_rd_hold", 32'(rd), 5);
        check("alu_data_hold", rd_data, 32'hDEADBEEF);

        // load formatting
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1; ld_rd = 3; ld_funct3 = t_f3[i]; ld_addr_lo = t_off[i];
            #1 check("ld_ready", 32'(ld_ready), 1);
            tick();
            ld_valid = 0;
            check("ld_pend_valid", 32'(pend_valid), 1);
            check("ld_pend_rd", 32'(pend_rd), 3);
            mem_rdata = 32'h80FF7F01; mem_rvalid = 1;
            tick();
            mem_rvalid = 0;
            check("ld_we", 32'(we), 1);
            check("ld_fmt_const", rd_data, t_exp[i]);
            check("ld_fmt_model", rd_data, ref_fmt(t_f3[i], t_off[i], 32'h80FF7F01));
            check("ld_pend_clear", 32'(pend_valid), 0);
        end

        // priority, stall, back-to-back
        ld_valid = 1; ld_rd = 9; ld_funct3 = 3'b010; ld_addr_lo = 0;
        alu_valid = 1; alu_rd = 7; alu_result = 32'h12345678;
        #1;
        check("prio_ld_ready", 32'(ld_ready), 1);
        check("prio_alu_ready", 32'(alu_ready), 0);
        tick();
        ld_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_alu_ready", 32'(alu_ready), 0);
            check("stall_pend_valid", 32'(pend_valid), 1);
            check("stall_pend_rd", 32'(pend_rd), 9);
            tick();
            check("stall_we", 32'(we), 0);
        end
        mem_rdata = 32'hCAFEF00D; mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        check("b2b_ld_we", 32'(we), 1);
        check("b2b_ld_rd", 32'(rd), 9);
        check("b2b_ld_data", rd_data, 32'hCAFEF00D);
        #1 check("b2b_alu_ready", 32'(alu_ready), 1);
        tick();
        alu_valid = 0;
        check("b2b_alu_we", 32'(we), 1);
        check("b2b_alu_rd", 32'(rd), 7);
        check("b2b_alu_data", rd_data, 32'h12345678);

        // suppression
        alu_valid = 1; alu_rd = 0; alu_result = 32'hFFFF0000;
        tick();
        alu_valid = 0;
        check("sup_x0_we", 32'(we), 0);
        check("sup_x0_rd_hold", 32'(rd), 7);
        ld_valid = 1; ld_rd = 17; ld_funct3 = 3'b010;
        tick();
        ld_valid = 0;
        check("sup17_pend_valid", 32'(pend_valid), 1);
        check("sup17_pend_rd", 32'(pend_rd), 17);
        mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        check("sup17_we", 32'(we), ref_writable(17) ? 1 : 0);
        check("sup17_pend_clear", 32'(pend_valid), 0);

        // stray mem_rvalid in IDLE
        mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        check("idle_rvalid_we", 32'(we), 0);

        // reset during LOAD_WAIT
        ld_valid = 1; ld_rd = 4;
        tick();
        ld_valid = 0;
        rst_n = 0;
        #1;
        check("rst_mid_pend_valid", 32'(pend_valid), 0);
        check("rst_mid_pend_rd", 32'(pend_rd), 0);
        tick();
        rst_n = 1;
        mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        check("rst_mid_no_write", 32'(we), 0);
        check("rst_mid_ld_ready", 32'(ld_ready), 1);

        // randomized traffic against the model
        m_pend = 0; m_rd = 0; m_f3 = 0; m_off = 0;
        last_rd = 0; last_data = 0;
        for (int n = 0; n < 400; n++) begin
            alu_valid  = ($urandom_range(0, 3) != 0);
            alu_rd     = 5'($urandom_range(0, 31));
            alu_result = $urandom;
            ld_valid   = ($urandom_range(0, 3) == 0);
            ld_rd      = 5'($urandom_range(0, 31));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            mem_rdata  = $urandom;
            mem_rvalid = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd_ld_ready", 32'(ld_ready), m_pend ? 0 : 1);
            check("rnd_alu_ready", 32'(alu_ready), (!m_pend && !ld_valid) ? 1 : 0);
            check("rnd_pend_valid", 32'(pend_valid), m_pend ? 1 : 0);
            check("rnd_pend_rd", 32'(pend_rd), m_pend ? 32'(m_rd) : 0);
            e_we = 0;
            if (m_pend) begin
                if (mem_rvalid) begin
                    m_pend = 0;
                    if (ref_writable(m_rd)) begin
                        e_we = 1; last_rd = m_rd;
                        last_data = ref_fmt(m_f3, m_off, mem_rdata);
                    end
                end
            end else if (ld_valid) begin
                m_pend = 1; m_rd = ld_rd; m_f3 = ld_funct3; m_off = ld_addr_lo;
            end else if (alu_valid && ref_writable(alu_rd)) begin
                e_we = 1; last_rd = alu_rd; last_data = alu_result;
            end
            @(posedge clk); #1;
            check("rnd_we", 32'(we), e_we ? 1 : 0);
            check("rnd_rd", 32'(rd), 32'(last_rd));
            check("rnd_data", rd_data, last_data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
